enigma_msg_ctrl: RTL
====================

ENIGMA_MSG_CTRL -- requirements
Module: enigma_msg_ctrl

Interface
REQ-001 Parameter SET_CYCLES, default 2: cycles enc_set is held high per configuration load (range 1..15).
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for enc_done (range 2..255).
REQ-003 The block SHALL use one clock, clk; reset is synchronous and active-high.
REQ-004 Ports, in order:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  pulse: (re)load key into engine
- dec_mode  in  1  sampled on accepted cfg_start
- cfg_busy  out  1  high while loading
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_last  in  1  last byte of message
- in_ready  out  1  input accept
- enc_set  out  1  to engine set
- enc_en  out  1  to engine en
- enc_dec  out  1  to engine dec
- enc_valid  out  1  to engine valid
- enc_din  out  8  to engine din
- enc_done  in  1  from engine done
- enc_dout  in  8  from engine dout
- out_valid  out  1  output byte valid
- out_data  out  8  output byte
- out_last  out  1  last byte of message
- out_ready  in  1  output accept
- msg_done  out  1  one-cycle pulse, message complete
- err_timeout  out  1  sticky engine timeout
- char_count  out  16  letters enciphered since last load

Function
REQ-005 States SHALL be IDLE, SET, READY, ISSUE, WAIT, HOLD, ERR; exactly one byte in flight at a time.
REQ-006 IDLE: in_ready=0; cfg_start -> SET.
REQ-007 SET: enc_set=1 and cfg_busy=1 for exactly SET_CYCLES cycles, then READY; dec_mode latched into enc_dec on cfg_start entry; char_count cleared on entry.
REQ-008 cfg_start SHALL be accepted only in IDLE, READY or ERR; ignored in SET, ISSUE, WAIT, HOLD.
REQ-009 READY: in_ready=1; transfer when in_valid & in_ready; in_last captured with the byte.
REQ-010 Accepted byte 0x41..0x5A ('A'..'Z') -> ISSUE; any other byte -> HOLD directly with out_data=in_data unchanged, engine untouched, char_count unchanged.
REQ-011 ISSUE: enc_valid=1 for exactly one cycle with enc_din=captured byte, then WAIT.
REQ-012 WAIT: on enc_done=1, capture enc_dout into out_data, char_count+1 (wraps 0xFFFF->0x0000), -> HOLD.
REQ-013 WAIT cycle counter starts at 0 on entry; if it reaches TIMEOUT without enc_done -> ERR, err_timeout=1.
REQ-014 HOLD: out_valid=1, out_data/out_last stable until out_valid & out_ready; then -> READY; if out_last, msg_done=1 that same transfer cycle.
REQ-015 enc_done outside WAIT SHALL be ignored.
REQ-016 ERR: in_ready=0, out_valid=0; err_timeout remains 1 until cfg_start, which clears it and enters SET.
REQ-017 enc_en SHALL be 1 in SET, READY, ISSUE, WAIT, HOLD; 0 in IDLE and ERR.
REQ-018 Outputs other than out_valid/in_ready/enc_valid/enc_set/msg_done are registered; no combinational path in_data->out_data.

Reset
REQ-019 On reset: state IDLE; cfg_busy, in_ready, enc_set, enc_en, enc_dec, enc_valid, out_valid, out_last, msg_done, err_timeout = 0; out_data, enc_din = 0x00; char_count = 0.
REQ-020 Reset mid-operation (any state) SHALL abandon the in-flight byte without emitting it and return to IDLE next cycle.

Verification
REQ-021 Load: cfg_start, dec_mode=0 -> enc_set high 2 cycles, cfg_busy high 2 cycles, in_ready=1 third cycle, enc_dec=0.
REQ-022 Letter: in 'H' (0x48), engine returns 0x51 after 14 cycles -> one enc_valid pulse with enc_din=0x48, out_data=0x51, char_count=1.
REQ-023 Bypass: in 0x20 with in_last=1 -> out_data=0x20 next cycle, enc_valid never asserted, msg_done pulse on output transfer, char_count unchanged.
REQ-024 Backpressure: out_ready=0 for 10 cycles -> out_valid/out_data stable, in_ready=0 throughout, no enc_valid.
REQ-025 Timeout: enc_done never asserted -> err_timeout=1 exactly TIMEOUT (64) cycles after WAIT entry; subsequent cfg_start clears it and reloads.
REQ-026 Reset during WAIT -> all outputs at REQ-019 values next cycle; late enc_done ignored.

Source files
------------

// File: rtl/enigma_msg_ctrl.sv
// Byte-stream controller for an Enigma-style cipher engine.
// Loads the key into the engine, sends letters through it one byte at a time,
// and passes every other byte straight to the output.
module enigma_msg_ctrl #(
    parameter int unsigned SET_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic        dec_mode,
    output logic        cfg_busy,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        enc_set,
    output logic        enc_en,
    output logic        enc_dec,
    output logic        enc_valid,
    output logic [7:0]  enc_din,
    input  logic        enc_done,
    input  logic [7:0]  enc_dout,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        msg_done,
    output logic        err_timeout,
    output logic [15:0] char_count
);

    localparam int unsigned SET_W = 4;
    localparam int unsigned TO_W  = 8;

    typedef enum logic [2:0] {
        IDLE, SET, READY, ISSUE, WAIT, HOLD, ERR
    } state_t;

    state_t            state, state_next;
    logic [SET_W-1:0]  set_cnt;
    logic [TO_W-1:0]   wait_cnt;
    logic              cfg_accept;
    logic              in_fire;
    logic              is_letter;
    logic              set_last;
    logic              timed_out;

    // Next state and the decoded handshake/strobe outputs.
    // A load request in READY takes priority over a byte, so in_ready drops then.
    always_comb begin
        state_next = state;
        cfg_accept = 1'b0;
        in_ready   = 1'b0;
        enc_set    = 1'b0;
        enc_valid  = 1'b0;
        out_valid  = 1'b0;
        msg_done   = 1'b0;
        in_fire    = 1'b0;
        is_letter  = (in_data >= 8'h41) && (in_data <= 8'h5A);
        set_last   = (set_cnt == SET_W'(SET_CYCLES - 1));
        timed_out  = (wait_cnt == TO_W'(TIMEOUT - 1));

        if ((state == IDLE) || (state == READY) || (state == ERR)) begin
            cfg_accept = cfg_start;
        end

        case (state)
            IDLE: begin
                if (cfg_accept) state_next = SET;
            end
            SET: begin
                enc_set = 1'b1;
                if (set_last) state_next = READY;
            end
            READY: begin
                in_ready = !cfg_start;
                in_fire  = in_valid && !cfg_start;
                if (cfg_accept) begin
                    state_next = SET;
                end else if (in_fire) begin
                    state_next = is_letter ? ISSUE : HOLD;
                end
            end
            ISSUE: begin
                enc_valid  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (enc_done) begin
                    state_next = HOLD;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    msg_done   = out_last;
                    state_next = READY;
                end
            end
            ERR: begin
                if (cfg_accept) state_next = SET;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and registered datapath outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            set_cnt     <= '0;
            wait_cnt    <= '0;
            cfg_busy    <= 1'b0;
            enc_en      <= 1'b0;
            enc_dec     <= 1'b0;
            enc_din     <= 8'h00;
            out_data    <= 8'h00;
            out_last    <= 1'b0;
            err_timeout <= 1'b0;
            char_count  <= 16'h0000;
        end else begin
            state    <= state_next;
            cfg_busy <= (state_next == SET);
            enc_en   <= (state_next != IDLE) && (state_next != ERR);

            if (cfg_accept) begin
                set_cnt     <= '0;
                enc_dec     <= dec_mode;
                char_count  <= 16'h0000;
                err_timeout <= 1'b0;
            end else if (state == SET) begin
                set_cnt <= set_cnt + SET_W'(1);
            end

            if (in_fire) begin
                out_last <= in_last;
                if (is_letter) begin
                    enc_din <= in_data;
                end else begin
                    out_data <= in_data;
                end
            end

            if (state == ISSUE) begin
                wait_cnt <= '0;
            end

            if (state == WAIT) begin
                if (enc_done) begin
                    out_data   <= enc_dout;
                    char_count <= char_count + 16'd1;
                end else begin
                    wait_cnt <= wait_cnt + TO_W'(1);
                    if (timed_out) err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule
